// File: rtl/alu_framer_pkg.sv
// Shared types for the ALU result framer: FSM state encoding.
package alu_framer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    FRAMING = 2'd2
  } framer_state_t;

endpackage

// File: rtl/alu_sync_fifo.sv
// Synchronous FIFO with occupancy level; read data is either registered on pop
// or a combinational peek at the head entry.
module alu_sync_fifo #(
  parameter int W       = 8,
  parameter int DEPTH   = 4,
  parameter bit REG_OUT = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wr_data,
  input  logic                     pop,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;

  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);
  // A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
  assign wr_ok = push && (!full || pop);
  assign rd_ok = pop && !empty;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  if (REG_OUT) begin : g_reg_out
    always_ff @(posedge clk) begin
      if (rst)        rd_data <= '0;
      else if (rd_ok) rd_data <= mem[rd_ptr];
    end
  end else begin : g_peek_out
    assign rd_data = mem[rd_ptr];
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/alu_framer_param.sv
// Buffers ALU result words and emits them as length-delimited frames with
// SOP/EOP markers, downstream stall, backpressure and sticky overflow flags.
//
// state   | meaning
// IDLE    | waiting for a length request; zero lengths are discarded here
// PENDING | length loaded, waiting until the whole frame is buffered
// FRAMING | popping one word per cycle that downstream is ready
module alu_framer_param
  import alu_framer_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 32,
  parameter int LEN_W     = 5,
  parameter int LQ_DEPTH  = 4,
  parameter int BP_THRESH = DEPTH - 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LEN_W-1:0]         frame_len,
  input  logic                     frame_len_val,
  output logic                     frame_len_rdy,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     alu_ready,
  input  logic                     frame_out_rdy,
  output logic                     frame,
  output logic                     frame_sop,
  output logic                     frame_eop,
  output logic [DATA_W-1:0]        frame_data,
  output logic                     frame_bp,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [1:0]               ovf_err
);
  localparam int LQ_AW = $clog2(LQ_DEPTH);
  localparam logic [LQ_AW:0] LQ_FULL = LQ_DEPTH[LQ_AW:0];
  localparam logic [LEN_W-1:0] LAST_WORD = 1;

  if ((2 ** LEN_W) - 1 > DEPTH) begin : g_len_w_too_wide
    $error("alu_framer_param: LEN_W allows frames longer than DEPTH");
  end

  framer_state_t        state;
  logic [LEN_W-1:0]     remaining;
  logic                 sop_pend;

  logic [LEN_W-1:0]     len_q;
  logic                 len_val_q;
  logic [DATA_W-1:0]    alu_data_q;
  logic                 alu_ready_q;

  logic                 d_pop;
  logic                 d_full;
  logic                 d_empty;
  logic                 l_pop;
  logic                 l_full;
  logic                 l_empty;
  logic [LEN_W-1:0]     l_head;
  logic [LQ_AW:0]       l_level;

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q       <= '0;
      len_val_q   <= 1'b0;
      alu_data_q  <= '0;
      alu_ready_q <= 1'b0;
    end else begin
      len_q       <= frame_len;
      len_val_q   <= frame_len_val;
      alu_data_q  <= alu_data;
      alu_ready_q <= alu_ready;
    end
  end

  assign d_pop = (state == FRAMING) && frame_out_rdy && !d_empty;
  assign l_pop = (state == IDLE) && !l_empty;
  assign frame_len_rdy = !l_full;

  alu_sync_fifo #(.W(DATA_W), .DEPTH(DEPTH), .REG_OUT(1'b1)) u_data_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (alu_ready_q),
    .wr_data (alu_data_q),
    .pop     (d_pop),
    .rd_data (frame_data),
    .full    (d_full),
    .empty   (d_empty),
    .level   (fifo_level)
  );

  // The length queue is read as a peek so IDLE can decide on the head in one cycle.
  alu_sync_fifo #(.W(LEN_W), .DEPTH(LQ_DEPTH), .REG_OUT(1'b0)) u_len_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (len_val_q),
    .wr_data (len_q),
    .pop     (l_pop),
    .rd_data (l_head),
    .full    (l_full),
    .empty   (l_empty),
    .level   (l_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      sop_pend  <= 1'b0;
      frame     <= 1'b0;
      frame_sop <= 1'b0;
      frame_eop <= 1'b0;
      frame_bp  <= 1'b0;
      ovf_err   <= 2'b00;
    end else begin
      frame     <= d_pop;
      frame_sop <= d_pop && sop_pend;
      frame_eop <= d_pop && (remaining == LAST_WORD);
      frame_bp  <= (int'(fifo_level) >= BP_THRESH);
      ovf_err[0] <= ovf_err[0] | (alu_ready_q & d_full & ~d_pop);
      ovf_err[1] <= ovf_err[1] | (len_val_q & (l_level == LQ_FULL) & ~l_pop);

      case (state)
        IDLE: begin
          if (!l_empty && (l_head != '0)) begin
            remaining <= l_head;
            sop_pend  <= 1'b1;
            state     <= PENDING;
          end
        end
        PENDING: begin
          if (int'(fifo_level) >= int'(remaining)) state <= FRAMING;
        end
        FRAMING: begin
          if (d_pop) begin
            remaining <= remaining - 1'b1;
            sop_pend  <= 1'b0;
            if (remaining == LAST_WORD) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_framer_param.sv
// Bench for alu_framer_param: table of frame cases checked through a beat
// scoreboard, plus hand-written sequences for queueing, overflow and reset.
module tb_alu_framer_param;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int LEN_W  = 5;

  logic              clk;
  logic              rst;
  logic [LEN_W-1:0]  frame_len;
  logic              frame_len_val;
  logic              frame_len_rdy;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              frame_out_rdy;
  logic              frame;
  logic              frame_sop;
  logic              frame_eop;
  logic [DATA_W-1:0] frame_data;
  logic              frame_bp;
  logic [5:0]        fifo_level;
  logic [1:0]        ovf_err;

  alu_framer_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W), .LQ_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_len     (frame_len),
    .frame_len_val (frame_len_val),
    .frame_len_rdy (frame_len_rdy),
    .alu_data      (alu_data),
    .alu_ready     (alu_ready),
    .frame_out_rdy (frame_out_rdy),
    .frame         (frame),
    .frame_sop     (frame_sop),
    .frame_eop     (frame_eop),
    .frame_data    (frame_data),
    .frame_bp      (frame_bp),
    .fifo_level    (fifo_level),
    .ovf_err       (ovf_err)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
  } beat_t;

  typedef struct {
    int len;
    int gap;
    int stall_at;
    int stall_n;
  } frame_vec_t;

  beat_t sb[$];
  int    beat_cyc[$];
  int    n_vec = 0;
  int    n_miss = 0;
  int    cyc = 0;
  int    last_push_cyc = 0;
  logic  rdy_prev = 1'b1;
  logic  mon_en = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rdy_prev <= frame_out_rdy;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Beat monitor: every emitted beat must have been granted and must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && frame && mon_en) begin
      beat_t e;
      beat_cyc.push_back(cyc);
      check("beat_granted", {63'd0, rdy_prev}, 64'd1);
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_beat: got data 0x%0h with empty scoreboard", frame_data);
      end else begin
        e = sb.pop_front();
        check("beat_data", {32'd0, frame_data}, {32'd0, e.data});
        check("beat_sop", {63'd0, frame_sop}, {63'd0, e.sop});
        check("beat_eop", {63'd0, frame_eop}, {63'd0, e.eop});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_len(input int len);
    frame_len     = LEN_W'(len);
    frame_len_val = 1'b1;
    tick();
    frame_len_val = 1'b0;
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w, input bit track, input bit sop, input bit eop);
    if (track) sb.push_back('{data: w, sop: sop, eop: eop});
    alu_data  = w;
    alu_ready = 1'b1;
    tick();
    alu_ready = 1'b0;
    last_push_cyc = cyc;
  endtask

  task automatic send_frame(input int len, input int gap);
    push_len(len);
    for (int i = 0; i < len; i++) begin
      push_word($urandom, 1'b1, i == 0, i == len - 1);
      repeat (gap) tick();
    end
  endtask

  task automatic drain(input int stall_at, input int stall_n);
    int c = 0;
    while (sb.size() > 0 && c < 200) begin
      frame_out_rdy = !(c >= stall_at && c < stall_at + stall_n);
      tick();
      c++;
    end
    frame_out_rdy = 1'b1;
    if (sb.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sb.size());
    end
    repeat (3) tick();
  endtask

  frame_vec_t vtab[5];

  initial begin
    vtab[0] = '{len: 4, gap: 0, stall_at: -1, stall_n: 0};
    vtab[1] = '{len: 3, gap: 1, stall_at: -1, stall_n: 0};
    vtab[2] = '{len: 6, gap: 0, stall_at: 4,  stall_n: 3};
    vtab[3] = '{len: 1, gap: 0, stall_at: -1, stall_n: 0};
    vtab[4] = '{len: 8, gap: 2, stall_at: -1, stall_n: 0};

    rst = 1'b1; frame_len = '0; frame_len_val = 1'b0;
    alu_data = '0; alu_ready = 1'b0; frame_out_rdy = 1'b1;
    repeat (2) tick();
    check("rst_frame", {63'd0, frame}, 64'd0);
    check("rst_sop_eop", {62'd0, frame_sop, frame_eop}, 64'd0);
    check("rst_data", {32'd0, frame_data}, 64'd0);
    check("rst_level", {58'd0, fifo_level}, 64'd0);
    check("rst_bp", {63'd0, frame_bp}, 64'd0);
    check("rst_ovf", {62'd0, ovf_err}, 64'd0);
    check("rst_len_rdy", {63'd0, frame_len_rdy}, 64'd1);
    rst = 1'b0;
    tick();

    // Table-driven single frames: plain, trickled words, mid-frame stall, 1-word, long trickle.
    for (int v = 0; v < 5; v++) begin
      beat_cyc.delete();
      send_frame(vtab[v].len, vtab[v].gap);
      drain(vtab[v].stall_at, vtab[v].stall_n);
      check("frame_beats", 64'(beat_cyc.size()), 64'(vtab[v].len));
      if (beat_cyc.size() > 0) begin
        check("first_beat_after_last_word", {63'd0, beat_cyc[0] > last_push_cyc}, 64'd1);
        if (vtab[v].stall_n == 0)
          check("beats_consecutive", 64'(beat_cyc[beat_cyc.size()-1] - beat_cyc[0]),
                64'(vtab[v].len - 1));
      end
      check("post_frame_level", {58'd0, fifo_level}, 64'd0);
      check("post_frame_idle", {63'd0, frame}, 64'd0);
    end

    // Queued lengths 2,0,1 over 3 pre-buffered words.
    beat_cyc.delete();
    frame_out_rdy = 1'b1;
    begin
      logic [DATA_W-1:0] w0, w1, w2;
      w0 = $urandom; w1 = $urandom; w2 = $urandom;
      push_word(w0, 1'b1, 1'b1, 1'b0);
      push_word(w1, 1'b1, 1'b0, 1'b1);
      push_word(w2, 1'b1, 1'b1, 1'b1);
      repeat (3) tick();
      check("buffered_level", {58'd0, fifo_level}, 64'd3);
      check("no_beat_without_len", 64'(beat_cyc.size()), 64'd0);
      push_len(2);
      push_len(0);
      push_len(1);
      drain(-1, 0);
      check("queued_beats", 64'(beat_cyc.size()), 64'd3);
      if (beat_cyc.size() == 3) begin
        check("q_frame0_consecutive", 64'(beat_cyc[1] - beat_cyc[0]), 64'd1);
        check("q_interframe_gap", {63'd0, (beat_cyc[2] - beat_cyc[1]) >= 2}, 64'd1);
      end
    end

    // Fill to overflow with nothing popping, then overflow the length queue.
    mon_en = 1'b0;
    frame_out_rdy = 1'b0;
    for (int i = 0; i < 28; i++) push_word($urandom, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    check("level_28", {58'd0, fifo_level}, 64'd28);
    check("bp_at_28", {63'd0, frame_bp}, 64'd0);
    push_word($urandom, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    check("level_29", {58'd0, fifo_level}, 64'd29);
    check("bp_at_29", {63'd0, frame_bp}, 64'd1);
    for (int i = 0; i < 3; i++) push_word($urandom, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    check("level_full", {58'd0, fifo_level}, 64'd32);
    check("ovf_not_yet", {62'd0, ovf_err}, 64'd0);
    push_word($urandom, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    check("level_after_ovf", {58'd0, fifo_level}, 64'd32);
    check("data_ovf", {62'd0, ovf_err}, 64'd1);
    check("bp_full", {63'd0, frame_bp}, 64'd1);
    push_len(31);
    repeat (4) tick();
    check("len_rdy_open", {63'd0, frame_len_rdy}, 64'd1);
    for (int i = 0; i < 4; i++) push_len(1);
    repeat (2) tick();
    check("len_rdy_full", {63'd0, frame_len_rdy}, 64'd0);
    check("len_ovf_not_yet", {62'd0, ovf_err}, 64'd1);
    push_len(1);
    repeat (2) tick();
    check("len_ovf", {62'd0, ovf_err}, 64'd3);

    // Reset mid-frame after a few beats have gone out.
    frame_out_rdy = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("mid_rst_frame", {63'd0, frame}, 64'd0);
    check("mid_rst_sop_eop", {62'd0, frame_sop, frame_eop}, 64'd0);
    check("mid_rst_data", {32'd0, frame_data}, 64'd0);
    check("mid_rst_level", {58'd0, fifo_level}, 64'd0);
    check("mid_rst_ovf", {62'd0, ovf_err}, 64'd0);
    check("mid_rst_bp", {63'd0, frame_bp}, 64'd0);
    check("mid_rst_len_rdy", {63'd0, frame_len_rdy}, 64'd1);
    rst = 1'b0;
    sb.delete();
    beat_cyc.delete();
    tick();
    mon_en = 1'b1;
    send_frame(1, 0);
    drain(-1, 0);
    check("post_rst_beats", 64'(beat_cyc.size()), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
